// File: rtl/fetch_btb.sv
// fetch_btb - branch target buffer for the fetch stage.
//
// Direct-mapped table of 2**IDXW entries (valid, tag, target). Fetch looks up
// QSLOTS instruction pointers in parallel with zero latency. Taken branches
// from the commit bus (up to 4 per cycle) are pushed into an update queue and
// written into the table one per clock while the block is idle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           invalidate all entries (restarts the valid-bit sweep)
//   ip[QSLOTS]      fetch lookup addresses
//   btb_hit         per-slot valid tag match
//   btb_tgt[QSLOTS] per-slot predicted target (meaningful only on hit)
//   xisBranch, xip, xtgt, takb
//                   commit-side branch outcome bus, 4 slots
//   busy            invalidate sweep in progress
//   drop_cnt        saturating count of updates lost to a full queue
module fetch_btb #(
    parameter int AMSB   = 79,
    parameter int QSLOTS = 2,
    parameter int IDXW   = 6,
    parameter int TAGW   = 16,
    parameter int QDEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [AMSB:0]     ip [QSLOTS],
    output logic [QSLOTS-1:0] btb_hit,
    output logic [AMSB:0]     btb_tgt [QSLOTS],
    input  logic [3:0]        xisBranch,
    input  logic [AMSB:0]     xip [4],
    input  logic [AMSB:0]     xtgt [4],
    input  logic [3:0]        takb,
    output logic              busy,
    output logic [15:0]       drop_cnt
);
    localparam int ENTRIES = 1 << IDXW;
    localparam int QPW     = $clog2(QDEPTH);
    localparam int CW      = QPW + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [IDXW-1:0]   sweep_r, sweep_s;

    // Table storage; contents are never reset, only the valid bits are swept.
    logic [ENTRIES-1:0] valid_r;
    logic [TAGW-1:0]    tag_mem_r [ENTRIES];
    logic [AMSB:0]      tgt_mem_r [ENTRIES];

    // Update queue
    logic [IDXW-1:0]   q_idx_r [QDEPTH];
    logic [TAGW-1:0]   q_tag_r [QDEPTH];
    logic [AMSB:0]     q_tgt_r [QDEPTH];
    logic [QPW-1:0]    head_r, tail_r;
    logic [CW-1:0]     count_r;
    logic [15:0]       drop_cnt_r;

    logic [CW-1:0]     free_s;
    logic [3:0]        wr_en_s;
    logic [QPW-1:0]    wr_pos_s [4];
    logic [2:0]        enq_s, drop_s;
    logic              deq_s;
    logic [16:0]       drop_sum_s;
    logic [15:0]       drop_nxt_s;
    logic [IDXW-1:0]   lk_idx_s [QSLOTS];
    logic              unused_bits_s;

    assign busy     = (state_r == ST_INIT);
    assign drop_cnt = drop_cnt_r;
    assign deq_s    = (state_r == ST_IDLE) && (count_r != CW'(0)) && !flush;

    // Next-state logic: sweep through every index, flush restarts the sweep.
    always_comb begin
        state_s = state_r;
        sweep_s = sweep_r;
        if (flush) begin
            state_s = ST_INIT;
            sweep_s = {IDXW{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    sweep_s = sweep_r + IDXW'(1);
                    if (sweep_r == {IDXW{1'b1}}) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_INIT;
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_INIT;
                    sweep_s = {IDXW{1'b0}};
                end
            endcase
        end
    end

    // Enqueue selection: space is what was free at the start of the cycle, so
    // the first qualifying slots (ascending) win and the rest are dropped.
    always_comb begin
        free_s = CW'(QDEPTH) - count_r;
        enq_s  = 3'd0;
        drop_s = 3'd0;
        for (int i = 0; i < 4; i++) begin
            wr_en_s[i]  = 1'b0;
            wr_pos_s[i] = tail_r + QPW'(enq_s);
            if (xisBranch[i] && takb[i]) begin
                if (CW'(enq_s) < free_s) begin
                    wr_en_s[i] = 1'b1;
                    enq_s      = enq_s + 3'd1;
                end else begin
                    drop_s = drop_s + 3'd1;
                end
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
        drop_sum_s = {1'b0, drop_cnt_r} + 17'(drop_s);
        if (drop_sum_s[16]) begin
            drop_nxt_s = 16'hFFFF;
        end else begin
            drop_nxt_s = drop_sum_s[15:0];
        end
    end

    // Control registers: state, sweep index, queue pointers, drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_INIT;
            sweep_r    <= {IDXW{1'b0}};
            head_r     <= {QPW{1'b0}};
            tail_r     <= {QPW{1'b0}};
            count_r    <= {CW{1'b0}};
            drop_cnt_r <= 16'h0000;
        end else begin
            state_r    <= state_s;
            sweep_r    <= sweep_s;
            head_r     <= head_r + QPW'(deq_s);
            tail_r     <= tail_r + QPW'(enq_s);
            count_r    <= count_r + CW'(enq_s) - CW'(deq_s);
            drop_cnt_r <= drop_nxt_s;
        end
    end

    // Queue storage: each accepted slot lands at its own precomputed tail offset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s[i]) begin
                q_idx_r[wr_pos_s[i]] <= xip[i][IDXW+1:2];
                q_tag_r[wr_pos_s[i]] <= xip[i][IDXW+TAGW+1:IDXW+2];
                q_tgt_r[wr_pos_s[i]] <= xtgt[i];
            end
        end
    end

    // Table write: sweep clears one valid bit per cycle, drain fills one entry.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            valid_r[sweep_r] <= 1'b0;
        end else if (deq_s) begin
            valid_r[q_idx_r[head_r]]   <= 1'b1;
            tag_mem_r[q_idx_r[head_r]] <= q_tag_r[head_r];
            tgt_mem_r[q_idx_r[head_r]] <= q_tgt_r[head_r];
        end
    end

    // Lookup: hits are suppressed until the sweep has finished.
    always_comb begin
        for (int n = 0; n < QSLOTS; n++) begin
            lk_idx_s[n] = ip[n][IDXW+1:2];
            btb_tgt[n]  = tgt_mem_r[lk_idx_s[n]];
            if ((state_r == ST_IDLE) && valid_r[lk_idx_s[n]] &&
                (tag_mem_r[lk_idx_s[n]] == ip[n][IDXW+TAGW+1:IDXW+2])) begin
                btb_hit[n] = 1'b1;
            end else begin
                btb_hit[n] = 1'b0;
            end
        end
    end

    // Address bits outside index and tag take no part in lookup or training.
    always_comb begin
        unused_bits_s = 1'b0;
        for (int n = 0; n < QSLOTS; n++) begin
            unused_bits_s = unused_bits_s ^ (^ip[n][1:0]) ^ (^ip[n][AMSB:IDXW+TAGW+2]);
        end
        for (int i = 0; i < 4; i++) begin
            unused_bits_s = unused_bits_s ^ (^xip[i][1:0]) ^ (^xip[i][AMSB:IDXW+TAGW+2]);
        end
    end
endmodule

// File: tb/tb_fetch_btb.sv
module tb_fetch_btb;
    localparam int AMSB = 79, QSLOTS = 2, IDXW = 6, TAGW = 16, QDEPTH = 16;
    localparam int ENTRIES = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [AMSB:0]     ip [QSLOTS];
    logic [QSLOTS-1:0] btb_hit;
    logic [AMSB:0]     btb_tgt [QSLOTS];
    logic [3:0]        xisBranch, takb;
    logic [AMSB:0]     xip [4];
    logic [AMSB:0]     xtgt [4];
    logic              busy;
    logic [15:0]       drop_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: a queue of pending updates and a table indexed by address.
    typedef struct { logic [AMSB:0] a; logic [AMSB:0] t; } upd_t;
    upd_t            mq[$];
    bit              m_valid [ENTRIES];
    logic [TAGW-1:0] m_tag [ENTRIES];
    logic [AMSB:0]   m_tgt [ENTRIES];
    int              m_sweep;
    int              m_drop;

    fetch_btb dut (
        .clk(clk), .rst(rst), .flush(flush), .ip(ip), .btb_hit(btb_hit),
        .btb_tgt(btb_tgt), .xisBranch(xisBranch), .xip(xip), .xtgt(xtgt),
        .takb(takb), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(logic [AMSB:0] a);
        return int'(a[IDXW+1:2]);
    endfunction

    function automatic logic [TAGW-1:0] tag_of(logic [AMSB:0] a);
        return a[IDXW+TAGW+1:IDXW+2];
    endfunction

    function automatic bit model_hit(logic [AMSB:0] a);
        int k = idx_of(a);
        return (m_sweep == 0) && m_valid[k] && (m_tag[k] == tag_of(a));
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_sweep = 64;
        m_drop = 0;
        for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    endfunction

    // One clock edge of the model, using the inputs currently applied.
    function automatic void model_step();
        int free = QDEPTH - mq.size();
        upd_t u;
        if (flush) begin
            m_sweep = 64;
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else if (mq.size() != 0) begin
            u = mq.pop_front();
            m_valid[idx_of(u.a)] = 1'b1;
            m_tag[idx_of(u.a)] = tag_of(u.a);
            m_tgt[idx_of(u.a)] = u.t;
        end
        for (int i = 0; i < 4; i++) begin
            if (xisBranch[i] && takb[i]) begin
                if (free > 0) begin
                    u.a = xip[i];
                    u.t = xtgt[i];
                    mq.push_back(u);
                    free--;
                end else begin
                    m_drop = (m_drop >= 65535) ? 65535 : m_drop + 1;
                end
            end
        end
    endfunction

    task automatic clear_inputs();
        flush = 1'b0;
        xisBranch = 4'b0000;
        takb = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            xip[i] = '0;
            xtgt[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int cyc = 0;
        clear_inputs();
        ip[0] = 80'h1000;
        ip[1] = 80'h1000;
        #3;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_cmp++; if (btb_hit !== 2'b00) begin n_fail++; $display("FAIL reset_hit: got %b expected 00", btb_hit); end
        n_cmp++; if (drop_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        while (busy === 1'b1 && cyc < 200) begin
            n_cmp++; if (btb_hit !== 2'b00) begin n_fail++; $display("FAIL sweep_hit: got %b expected 00 at cycle %0d", btb_hit, cyc); end
            cyc++;
            tick();
        end
        n_cmp++; if (cyc != 64) begin n_fail++; $display("FAIL sweep_len: got %0d expected 64", cyc); end
        n_cmp++; if (btb_hit !== 2'b00) begin n_fail++; $display("FAIL post_sweep_hit: got %b expected 00", btb_hit); end
    endtask

    task automatic test_single();
        xisBranch = 4'b0001; takb = 4'b0001;
        xip[0] = 80'h1000; xtgt[0] = 80'h2000;
        ip[0] = 80'h1000; ip[1] = 80'h1100;
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (btb_hit[0] !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b expected 0", btb_hit[0]); end
        tick();
        n_cmp++; if (btb_hit !== 2'b01) begin n_fail++; $display("FAIL single_hit: got %b expected 01", btb_hit); end
        n_cmp++; if (btb_tgt[0] !== 80'h2000) begin n_fail++; $display("FAIL single_tgt: got %h expected 2000", btb_tgt[0]); end
    endtask

    task automatic test_mixed();
        xisBranch = 4'b1111; takb = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            xip[i] = 80'h3000 + 80'(i * 4);
            xtgt[i] = 80'h9000 + 80'(i);
        end
        tick();
        clear_inputs();
        repeat (2) tick();
        ip[0] = 80'h3004; ip[1] = 80'h300C;
        #1;
        n_cmp++; if (btb_hit !== 2'b11) begin n_fail++; $display("FAIL mixed_hit: got %b expected 11", btb_hit); end
        n_cmp++; if (btb_tgt[0] !== 80'h9001 || btb_tgt[1] !== 80'h9003) begin
            n_fail++; $display("FAIL mixed_tgt: got %h %h expected 9001 9003", btb_tgt[0], btb_tgt[1]);
        end
        ip[0] = 80'h3000; ip[1] = 80'h3008;
        #1;
        n_cmp++; if (btb_hit !== 2'b00) begin n_fail++; $display("FAIL mixed_nt_miss: got %b expected 00", btb_hit); end
    endtask

    task automatic test_alias();
        xisBranch = 4'b0011; takb = 4'b0011;
        xip[0] = 80'h7010; xtgt[0] = 80'hAAA0;
        xip[1] = 80'h8010; xtgt[1] = 80'hBBB0;
        tick();
        clear_inputs();
        repeat (2) tick();
        ip[0] = 80'h8010; ip[1] = 80'h7010;
        #1;
        n_cmp++; if (btb_hit !== 2'b01) begin n_fail++; $display("FAIL alias_hit: got %b expected 01", btb_hit); end
        n_cmp++; if (btb_tgt[0] !== 80'hBBB0) begin n_fail++; $display("FAIL alias_tgt: got %h expected bbb0", btb_tgt[0]); end
    endtask

    task automatic test_overflow();
        int cyc = 0;
        for (int c = 0; c < 5; c++) begin
            flush = 1'b1;
            xisBranch = 4'b1111; takb = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                xip[i] = 80'h5000 + 80'((c * 4 + i) * 4);
                xtgt[i] = 80'hC0000 + 80'(c * 4 + i);
            end
            tick();
        end
        n_cmp++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_drop: got %0d expected 4", drop_cnt); end
        clear_inputs();
        ip[0] = 80'h5000; ip[1] = 80'h5004;
        #1;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        n_cmp++; if (cyc != 64) begin n_fail++; $display("FAIL ovf_sweep_len: got %0d expected 64", cyc); end
        repeat (15) tick();
        ip[0] = 80'h5038; ip[1] = 80'h503C;
        #1;
        n_cmp++; if (btb_hit !== 2'b01) begin n_fail++; $display("FAIL ovf_drain15: got %b expected 01", btb_hit); end
        tick();
        for (int k = 0; k < 20; k++) begin
            ip[0] = 80'h5000 + 80'(k * 4);
            #1;
            n_cmp++; if (btb_hit[0] !== (k < 16)) begin n_fail++; $display("FAIL ovf_entry%0d: got %b expected %b", k, btb_hit[0], k < 16); end
            if (k < 16) begin
                n_cmp++; if (btb_tgt[0] !== 80'hC0000 + 80'(k)) begin n_fail++; $display("FAIL ovf_tgt%0d: got %h expected %h", k, btb_tgt[0], 80'hC0000 + 80'(k)); end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int cyc = 0;
        xisBranch = 4'b1111; takb = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            xip[i] = 80'hA000 + 80'(i * 4);
            xtgt[i] = 80'hD000 + 80'(i);
        end
        tick();
        xisBranch = 4'b0011; takb = 4'b0011;
        xip[0] = 80'hB010; xip[1] = 80'hB014;
        tick();
        clear_inputs();
        ip[0] = 80'hA000; ip[1] = 80'hA004;
        #1;
        n_cmp++; if (btb_hit !== 2'b01) begin n_fail++; $display("FAIL pre_rst_hit: got %b expected 01", btb_hit); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
        n_cmp++; if (btb_hit !== 2'b00) begin n_fail++; $display("FAIL rst_mid_hit: got %b expected 00", btb_hit); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        n_cmp++; if (cyc != 64) begin n_fail++; $display("FAIL rst_sweep_len: got %0d expected 64", cyc); end
        repeat (10) tick();
        for (int k = 0; k < 6; k++) begin
            ip[0] = (k < 4) ? 80'hA000 + 80'(k * 4) : 80'hB010 + 80'((k - 4) * 4);
            #1;
            n_cmp++; if (btb_hit[0] !== 1'b0) begin n_fail++; $display("FAIL stale_entry%0d: got %b expected 0", k, btb_hit[0]); end
        end
    endtask

    function automatic logic [AMSB:0] rand_addr();
        logic [AMSB:0] a = '0;
        a[1:0] = 2'($urandom);
        a[IDXW+1:2] = IDXW'($urandom_range(0, 7));
        a[IDXW+TAGW+1:IDXW+2] = TAGW'($urandom_range(0, 3));
        a[AMSB:AMSB-7] = 8'($urandom);
        return a;
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 99) == 0);
            xisBranch = 4'($urandom);
            takb = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                xip[i] = rand_addr();
                xtgt[i] = {16'($urandom), $urandom, $urandom};
            end
            for (int n = 0; n < QSLOTS; n++) ip[n] = rand_addr();
            #1;
            n_cmp++; if (busy !== (m_sweep != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, m_sweep != 0); end
            n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop c%0d: got %0d expected %0d", c, drop_cnt, m_drop); end
            for (int n = 0; n < QSLOTS; n++) begin
                n_cmp++; if (btb_hit[n] !== model_hit(ip[n])) begin
                    n_fail++; $display("FAIL rnd_hit c%0d s%0d: got %b expected %b", c, n, btb_hit[n], model_hit(ip[n]));
                end
                if (model_hit(ip[n])) begin
                    n_cmp++; if (btb_tgt[n] !== m_tgt[idx_of(ip[n])]) begin
                        n_fail++; $display("FAIL rnd_tgt c%0d s%0d: got %h expected %h", c, n, btb_tgt[n], m_tgt[idx_of(ip[n])]);
                    end
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_mixed();
        test_alias();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_btb.md
Name: fetch_btb

Overview:
- Branch target buffer sitting beside the g-share predictor in the fetch stage.
- Fetch presents the same QSLOTS instruction pointers to both blocks. This block returns a per-slot hit flag and predicted target.
- The next-IP mux redirects fetch only when predict_taken and btb_hit are both asserted for a slot.
- Training comes from the commit-side branch outcome bus (up to 4 per cycle). Outcomes are queued and written one per clock.

Parameters:
- AMSB, 79, MSB of instruction pointer / target addresses.
- QSLOTS, 2, number of fetch slots looked up in parallel.
- IDXW, 6, index width; table holds 2**IDXW entries, index = ip[IDXW+1:2].
- TAGW, 16, tag width; tag = ip[IDXW+TAGW+1:IDXW+2].
- QDEPTH, 16, update queue depth (power of two).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- flush, in, 1, invalidate all entries (restart sweep).
- ip, in, [AMSB:0] x QSLOTS, fetch lookup addresses.
- btb_hit, out, QSLOTS, per-slot valid tag match.
- btb_tgt, out, [AMSB:0] x QSLOTS, per-slot predicted target.
- xisBranch, in, 4, commit slot carries a resolved branch.
- xip, in, [AMSB:0] x 4, committed branch address.
- xtgt, in, [AMSB:0] x 4, resolved branch target.
- takb, in, 4, branch was taken.
- busy, out, 1, invalidate sweep in progress.
- drop_cnt, out, 16, saturating count of updates lost to a full queue.

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-high (rst).
- Reset values:
  - State = INIT, sweep index = 0.
  - busy = 1, drop_cnt = 0.
  - Queue head = tail = 0, count = 0.
  - btb_hit = 0 for all slots.
  - Table contents are not reset; only the valid bits are cleared, by the sweep.
- State machine:
  - INIT: each cycle clears the valid bit at the sweep index, then increments it.
  - When index = 2**IDXW-1 is cleared, the next state is IDLE. Sweep lasts 2**IDXW cycles.
  - busy = 1 throughout INIT.
  - IDLE: drains the queue. flush in any state forces INIT with index 0 on the next edge; flush during INIT restarts the sweep.
- Lookup (combinational, zero latency):
  - btb_hit[n] = state==IDLE && valid[idx(ip[n])] && tag[idx(ip[n])]==tag(ip[n]).
  - btb_tgt[n] = stored target. Its value is don't-care when btb_hit[n]=0; the bench checks it only on hit.
- Enqueue:
  - Each cycle, slots 0..3 are scanned in ascending order. A slot qualifies when xisBranch[i] && takb[i].
  - Not-taken branches are ignored; no invalidation occurs on not-taken.
  - Free space = QDEPTH - count at the start of the cycle. A same-cycle dequeue gives no credit.
  - The first min(free, qualifying) slots in ascending order are written at tail. The remainder are dropped.
  - drop_cnt adds the number dropped and saturates at 16'hFFFF.
  - Enqueue proceeds in all states, including INIT.
- Dequeue:
  - Only in IDLE, when count != 0 and flush = 0.
  - Writes valid = 1, tag and target into the entry indexed by the head address. An existing entry is overwritten unconditionally; the table is direct-mapped.
  - head increments.
  - The write becomes visible to lookup on the cycle after the edge; there is no bypass.
- Pointers wrap modulo QDEPTH. count = 0..QDEPTH, updated as count + enq - deq.
- flush does not empty the queue. Queued updates drain after the new sweep completes.
- Reset mid-sweep or mid-drain: all state returns to reset values immediately. The queue is emptied.

Test Plan:
- Reset release, no updates:
  - busy = 1 for exactly 64 cycles, then 0.
  - Lookup ip = 80'h1000 during and after the sweep → btb_hit = 0.
- Single update: xisBranch = 4'b0001, takb = 4'b0001, xip[0] = 80'h1000, xtgt[0] = 80'h2000, applied after busy falls.
  - The queue write occurs on the next edge.
  - ip[0] = 80'h1000 hits with btb_tgt = 80'h2000 two cycles after the input cycle.
  - ip[1] = 80'h1100 (same index, different tag) → miss.
- Mixed slots: xisBranch = 4'b1111, takb = 4'b1010 → exactly 2 entries queued (slots 1, 3).
  - Both hit after 3 cycles.
  - Slots 0 and 2 addresses miss.
- Overflow:
  - Hold flush = 1. Feed 4 taken branches per cycle for 5 cycles.
  - Queue fills to 16; drop_cnt = 4.
  - Release flush: entries drain over 16 cycles after the 64-cycle sweep.
- Aliasing: two taken branches with the same index, enqueued as slots 0 then 1.
  - After the drain, only the slot 1 tag/target hits.
- Async reset asserted mid-drain, with count = 5:
  - busy = 1 and btb_hit = 0 immediately.
  - After release, a full 64-cycle sweep runs and no stale queued updates are written.
